// File: rtl/sum_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// The seven-segment table is only referenced when SUM_BCD_SEG_EN is defined.
package sum_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // {g,f,e,d,c,b,a}, active-high; codes 10-15 blank
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
    };

    // True when 10^digits exceeds the largest in_w-bit value
    function automatic bit digits_cover_width(input int unsigned in_w, input int unsigned digits);
        longint unsigned p10;
        longint unsigned max_in;
        p10    = 64'd1;
        max_in = (64'd1 << in_w) - 64'd1;
        for (int unsigned k = 0; k < digits; k++) begin
            if (p10 <= max_in) p10 = p10 * 64'd10;
        end
        return (p10 > max_in);
    endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// One BCD digit to seven-segment pattern {g,f,e,d,c,b,a}, active-high.
module bcd_seg7_decode
    import sum_bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = SEG7_LUT[i_digit];

endmodule

// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble converter: binary sum in, packed BCD out, one bit per cycle.
// Define SUM_BCD_SEG_EN to add the per-digit seven-segment output port seg.
module sum_bcd_converter
    import sum_bcd_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
`ifdef SUM_BCD_SEG_EN
    output logic [7*DIGITS-1:0]   seg,
`endif
    output logic                  busy
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    if (!digits_cover_width(IN_W, DIGITS)) begin : g_bad_params
        $error("sum_bcd_converter: DIGITS too small for IN_W");
    end

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_accept;
    logic                     w_last;
    logic [CNT_W-1:0]         r_cnt;
    logic [IN_W-1:0]          r_shreg;
    logic [BCD_W-1:0]         r_bcd;
    logic [BCD_W-1:0]         r_out_bcd;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_busy;
    logic [BCD_W-1:0]         w_adj;
    logic [BCD_W+IN_W-1:0]    w_step;

    // Add-3 on every digit >= 5; no carry can leave a digit
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (r_bcd[4*k +: 4] >= BCD_ADJ_THRESH) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + BCD_ADJ_ADD;
            end
        end
    end

    assign w_step = {w_adj, r_shreg} << 1;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Handshake/status outputs follow the next state so they are registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt == ST_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_bcd     <= '0;
            r_out_bcd <= '0;
        end else if (w_accept) begin
            r_cnt   <= CNT_W'(IN_W);
            r_shreg <= in_data;
            r_bcd   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_shreg <= w_step[IN_W-1:0];
            r_bcd   <= w_step[BCD_W+IN_W-1:IN_W];
            if (w_last) r_out_bcd <= w_step[BCD_W+IN_W-1:IN_W];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_bcd   = r_out_bcd;

`ifdef SUM_BCD_SEG_EN
    for (genvar k = 0; k < int'(DIGITS); k++) begin : g_seg
        bcd_seg7_decode u_seg7 (
            .i_digit (r_out_bcd[4*k +: 4]),
            .o_seg   (seg[7*k +: 7])
        );
    end
`endif

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Scoreboard bench for sum_bcd_converter: decimal reference model, directed and random traffic.
// Seven-segment checks are compiled in when SUM_BCD_SEG_EN is defined.
module tb_sum_bcd_converter;

    localparam int unsigned IN_W   = 8;
    localparam int unsigned DIGITS = 3;
    localparam int unsigned BCD_W  = 4 * DIGITS;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_data   = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BCD_W-1:0]  out_bcd;
    logic              busy;
`ifdef SUM_BCD_SEG_EN
    logic [7*DIGITS-1:0] seg;
`endif

    sum_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
`ifdef SUM_BCD_SEG_EN
        .seg       (seg),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [BCD_W-1:0] sb_q[$];
    logic [BCD_W-1:0] last_bcd   = '0;
    bit               mon_on     = 1'b0;
    bit               prev_valid = 1'b0;
    bit               m_idle     = 1'b1;
    int               m_busy_cnt = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // Decimal digits by repeated division
    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
        logic [BCD_W-1:0] r;
        int unsigned      x;
        r = '0;
        x = v;
        for (int k = 0; k < int'(DIGITS); k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

`ifdef SUM_BCD_SEG_EN
    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction
`endif

    // Monitor: timing model plus scoreboard pop on every new result
    always @(negedge clk) begin
        if (mon_on) begin
            check("in_ready", in_ready, m_idle);
            check("busy", busy, (m_busy_cnt > 0));
            check("out_valid", out_valid, (!m_idle && m_busy_cnt == 0));
            if (out_valid && !prev_valid) begin
                if (sb_q.size() == 0) timeout("unexpected_out");
                else last_bcd = sb_q.pop_front();
            end
            check("out_bcd", out_bcd, last_bcd);
`ifdef SUM_BCD_SEG_EN
            for (int k = 0; k < int'(DIGITS); k++) check("seg", seg[7*k +: 7], seg_ref(last_bcd[4*k +: 4]));
`endif
            prev_valid = out_valid;
            if (!rst) begin
                sb_q.delete();
                last_bcd   = '0;
                m_idle     = 1'b1;
                m_busy_cnt = 0;
                prev_valid = 1'b0;
            end else if (m_idle) begin
                if (in_valid) begin
                    sb_q.push_back(to_bcd(int'(in_data)));
                    m_idle     = 1'b0;
                    m_busy_cnt = IN_W;
                end
            end else if (m_busy_cnt > 0) begin
                m_busy_cnt--;
            end else if (out_ready) begin
                m_idle = 1'b1;
            end
        end
    end

    task automatic send(input logic [IN_W-1:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("send");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = IN_W'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && in_ready && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_idle");
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_valid");
    endtask

    initial begin
        logic [IN_W-1:0] bvals [4];
        bit              ok;
        bvals = '{8'd0, 8'd9, 8'd99, 8'd255};

        // Reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        check("rst_bcd", out_bcd, 12'h000);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b1);

        // Full sum and boundary values, consumer always ready
        out_ready = 1'b1;
        send(8'd136);
        wait_idle();
        foreach (bvals[i]) begin
            send(bvals[i]);
            wait_idle();
        end

        // Back-pressure in DONE with a competing input
        out_ready = 1'b0;
        send(8'd136);
        wait_valid();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'd77;
        repeat (5) begin
            @(negedge clk);
            check("hold_bcd", out_bcd, 12'h136);
            check("hold_valid", out_valid, 1'b1);
            check("hold_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("resume");
        @(posedge clk); #1 in_valid = 1'b0;
        wait_idle();

        // Reset during the fourth shift cycle of 200
        send(8'd200);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_bcd", out_bcd, 12'h000);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", in_ready, 1'b1);
        repeat (20) @(posedge clk);

        // Random traffic with random back-pressure
        repeat (600) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = IN_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sum_bcd_converter.md
Name: sum_bcd_converter

Overview:
Downstream consumer of the running-sum accumulator. It accepts one binary sum per valid/ready handshake and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per cycle. It then holds the BCD result for the display or readout stage until that stage takes it.

Parameters:
IN_W, 8, width of the binary input sum.
DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^IN_W - 1; an elaboration-time check fails the build otherwise.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low; sampled on rising edge of clk
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept an input this cycle
in_data  input  IN_W  binary sum to convert, unsigned
out_valid  output  1  out_bcd holds a completed conversion
out_ready  input  1  downstream accepts out_bcd this cycle
out_bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0]
busy  output  1  conversion in progress (state SHIFT)

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Encoding comes from the package.
- Reset (rst==0 at a clk edge):
  - state=IDLE, bit counter=0, shift register=0, BCD working register=0.
  - out_bcd=0, out_valid=0, busy=0, in_ready=1 from the next cycle.
  - Takes priority over every other event, including mid-SHIFT and mid-DONE. An in-flight conversion is discarded with no output.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture in_data into the shift register, clear the BCD working register, load counter=IN_W, go to SHIFT.
- SHIFT (busy=1, in_ready=0):
  - Each cycle, first add 3 to every working BCD digit that is >=5.
  - Then shift {bcd, shreg} left by one; shreg MSB enters BCD bit 0.
  - Counter decrements each cycle. When counter==1 at the edge, the final shift completes, out_bcd is loaded from the shifted result, and the FSM goes to DONE.
  - Exactly IN_W cycles are spent in SHIFT.
- DONE:
  - out_valid=1, in_ready=0.
  - On out_ready, go to IDLE and deassert out_valid.
  - out_bcd stays stable while out_valid=1 and is held (not cleared) after the handshake until the next conversion completes.
- Latency: an input accepted at edge T gives out_valid=1 after edge T+IN_W. Back-to-back throughput is one result per IN_W+2 cycles.
- No overlap: in_valid is ignored outside IDLE. in_data only needs to be stable at the accepting edge.
- out_ready while out_valid=0 has no effect.
- Arithmetic: the add-3 is per 4-bit digit with no inter-digit carry (guaranteed by the >=5 rule). The top digit never exceeds 9 for legal parameters.
- in_data=0 converts normally to all-zero BCD in the same IN_W cycles; there is no early exit.

Optional Feature:
Macro SUM_BCD_SEG_EN.
- Defined:
  - Adds output port seg, width 7*DIGITS, after out_bcd.
  - Per digit k, seg[7k+6:7k] = {g,f,e,d,c,b,a}, active-high, decoded combinationally from out_bcd digit k.
  - Codes 10-15 decode to blank (all 0).
  - Reset value follows out_bcd=0, i.e. each digit shows "0" = 7'b0111111.
- Undefined: no seg port and no decoder logic. Port list and behaviour are otherwise identical.

Decomposition:
- Package sum_bcd_pkg:
  - FSM state typedef (IDLE/SHIFT/DONE).
  - Constant BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3.
  - 16-entry seven-segment lookup constant, used only under SUM_BCD_SEG_EN.
- Sub-module bcd_seg7_decode (4-bit BCD in, 7-bit segments out), instantiated DIGITS times under the macro.
- The double-dabble step stays inline in sum_bcd_converter.

Test Plan:
1. rst=0 for 2 edges, then release -> out_bcd=12'h000, out_valid=0, busy=0, in_ready=1.
2. in_data=136 (full 0..16 sum) with out_ready=1 -> out_valid rises exactly 8 cycles after acceptance, out_bcd=12'h136, then returns to IDLE next edge.
3. Boundary values 0, 9, 99, 255 -> out_bcd=12'h000, 12'h009, 12'h099, 12'h255, each with 8-cycle latency.
4. out_ready held 0 for 5 cycles in DONE while in_valid=1 with new data -> out_bcd=12'h136 stable, out_valid=1, in_ready=0, new data not taken. Raise out_ready -> IDLE, then the next input is accepted.
5. rst=0 asserted at 4th SHIFT cycle of a conversion of 200 -> next cycle IDLE, out_valid=0, out_bcd=0, no 12'h200 ever produced.
6. With SUM_BCD_SEG_EN, convert 136 -> seg digit2=7'b0000110, digit1=7'b1001111, digit0=7'b1111101. Without the macro, the build has no seg port.
